// File: rtl/uart_boot_sequencer_if.sv
// Byte-stream input and memory write port of the UART boot sequencer.
// The sequencer uses the slave side. The UART/memory side (or a testbench) uses master.
interface uart_boot_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_boot_sequencer.sv
// UART boot-load controller.
// It holds the CPU in reset while a length-prefixed image is received.
// The image is written into SRAM as little-endian 32-bit words.
// A trailing 8-bit additive checksum of the data bytes is then verified.
// A good checksum releases the CPU. Anything else parks in ERR with cpu_rst held.
module uart_boot_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    read_uart,
  uart_boot_sequencer_if.slave    bus,
  output logic                    cpu_rst,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       len_next_s;
  logic [31:0]       word_next_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    word_d      = word_q;
    csum_d      = csum_q;
    to_cnt_d    = to_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    // Bytes arrive LSB first, so each new byte shifts in from the top
    len_next_s  = {bus.rx_data, len_q[31:8]};
    word_next_s = {bus.rx_data, word_q[31:8]};

    if (read_uart) begin
      // A request restarts from any state, and it beats a same-cycle timeout or error
      state_d    = ST_LEN;
      byte_cnt_d = 2'd0;
      word_cnt_d = 32'd0;
      len_d      = 32'd0;
      word_d     = 32'd0;
      csum_d     = 8'd0;
      to_cnt_d   = '0;
      cpu_rst_d  = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cpu_rst_d = 1'b0;
          busy_d    = 1'b0;
        end
        ST_ERR: begin
          cpu_rst_d = 1'b1;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end
        ST_LEN, ST_DATA, ST_CSUM: begin
          if (bus.rx_valid) begin
            // An accepted byte always wins over the timeout limit
            to_cnt_d = '0;
            case (state_q)
              ST_LEN: begin
                len_d      = len_next_s;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                  if (len_next_s > 32'(MAX_WORDS)) begin
                    state_d   = ST_ERR;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    cpu_rst_d = 1'b1;
                  end else if (len_next_s == 32'd0) begin
                    state_d = ST_CSUM;
                  end else begin
                    state_d = ST_DATA;
                  end
                end else begin
                  state_d = ST_LEN;
                end
              end
              ST_DATA: begin
                word_d     = word_next_s;
                csum_d     = csum_q + bus.rx_data;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ADDR_W'(BASE_ADDR) + word_cnt_q[ADDR_W-1:0];
                  mem_wdata_d = word_next_s;
                  word_cnt_d  = word_cnt_q + 32'd1;
                  if (word_cnt_q == len_q - 32'd1) begin
                    state_d = ST_CSUM;
                  end else begin
                    state_d = ST_DATA;
                  end
                end else begin
                  state_d = ST_DATA;
                end
              end
              ST_CSUM: begin
                busy_d = 1'b0;
                if (bus.rx_data == csum_q) begin
                  state_d   = ST_IDLE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
                end else begin
                  state_d   = ST_ERR;
                  err_d     = 1'b1;
                  cpu_rst_d = 1'b1;
                end
              end
              default: begin
                state_d = ST_IDLE;
              end
            endcase
          end else if (to_cnt_q == TO_LIMIT) begin
            // The link went quiet for TIMEOUT_CYC cycles in a row
            state_d   = ST_ERR;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
          end
        end
        default: begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset holds the CPU and clears everything else
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= 32'd0;
      len_q       <= 32'd0;
      word_q      <= 32'd0;
      csum_q      <= 8'd0;
      to_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      to_cnt_q    <= to_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign busy          = busy_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule
